// File: rtl/wall_detection_pkg.sv
// Shared definitions for the wall-detect code word link.
// Field layout, safe obstacle value and decoder state encoding.
package wall_detection_pkg;

   localparam int OBST_W = 3;
   localparam int CODE_W = 8;

   localparam int PAR_HI   = 7;
   localparam int PAR_LO   = 6;
   localparam int COPY_MSB = 5;
   localparam int COPY_LSB = 3;
   localparam int DATA_MSB = 2;
   localparam int DATA_LSB = 0;

   localparam logic [OBST_W-1:0] OBST_SAFE = 3'b111;

   typedef enum logic [1:0] {
      LOST    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } wd_state_t;

endpackage

// File: rtl/wall_detection_decoder_checker.sv
// Combinational validity check of one wall-detect code word.
// Reusable by any consumer of the same code.
module wall_code_checker
   import wall_detection_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic              good,
   output logic [OBST_W-1:0] data
);

   logic par_ok;
   logic copy_ok;
   logic par_val;

   always_comb begin
      data    = code[DATA_MSB:DATA_LSB];
      par_ok  = code[PAR_HI] == code[PAR_LO];
      copy_ok = code[COPY_MSB:COPY_LSB] == data;
      par_val = code[PAR_HI] == (^data);
      good    = par_ok && copy_ok && par_val;
   end

endmodule

// File: rtl/wall_detection_decoder.sv
// Wall-detect link receiver: qualifies obstacle data over a run of
// identical good words and declares link loss after a silent period.
module wall_detection_decoder
   import wall_detection_pkg::*;
#(
   parameter int STABLE_COUNT   = 3,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int ERR_CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [CODE_W-1:0]    code_in,
   input  logic                 code_valid,
   input  logic                 err_clr,
   output logic [OBST_W-1:0]    obst_out,
   output logic                 obst_valid,
   output logic                 obst_update,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 link_lost
);

   localparam int RUN_W = (STABLE_COUNT < 2) ? 1 : $clog2(STABLE_COUNT + 1);
   localparam int TW    = $clog2(TIMEOUT_CYCLES);

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_COUNT);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
   localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT_CYCLES - 1);

   wd_state_t            state, state_n;
   logic [RUN_W-1:0]     run_cnt, run_n;
   logic [OBST_W-1:0]    cand, cand_n;
   logic [OBST_W-1:0]    obst_n;
   logic [TW-1:0]        tcnt, tcnt_n;
   logic [ERR_CNT_W-1:0] err_n;
   logic                 upd_n;

   logic              good;
   logic [OBST_W-1:0] data;
   logic              gw, bad, match, qual;

   wall_code_checker u_chk (
      .code (code_in),
      .good (good),
      .data (data)
   );

   always_comb begin
      state_n = state;
      run_n   = run_cnt;
      cand_n  = cand;
      obst_n  = obst_out;
      tcnt_n  = tcnt;
      err_n   = err_count;
      upd_n   = 1'b0;
      gw      = code_valid && good;
      bad     = code_valid && !good;
      match   = (data == cand) && (run_cnt != '0);
      qual    = 1'b0;

      if (err_clr)
         err_n = '0;
      else if (bad && (err_count != '1))
         err_n = err_count + 1'b1;

      if (gw) begin
         tcnt_n = '0;
         if (match) begin
            if (run_cnt != RUN_MAX)
               run_n = run_cnt + 1'b1;
            qual = run_cnt == (RUN_MAX - 1'b1);
         end else begin
            cand_n = data;
            run_n  = RUN_ONE;
            qual   = (STABLE_COUNT == 1);
         end
         if (qual) begin
            state_n = LOCKED;
            if ((state != LOCKED) || (data != obst_out)) begin
               obst_n = data;
               upd_n  = 1'b1;
            end
         end else if (state == LOST) begin
            state_n = ACQUIRE;
         end
      end else begin
         if (bad)
            run_n = '0;
         // Counter parks at its last value; only a live link can time out.
         if (tcnt == T_LAST) begin
            if (state != LOST) begin
               state_n = LOST;
               obst_n  = OBST_SAFE;
               run_n   = '0;
            end
         end else begin
            tcnt_n = tcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= LOST;
         run_cnt     <= '0;
         cand        <= '0;
         tcnt        <= '0;
         obst_out    <= OBST_SAFE;
         obst_valid  <= 1'b0;
         obst_update <= 1'b0;
         err_pulse   <= 1'b0;
         err_count   <= '0;
         link_lost   <= 1'b1;
      end else begin
         state       <= state_n;
         run_cnt     <= run_n;
         cand        <= cand_n;
         tcnt        <= tcnt_n;
         obst_out    <= obst_n;
         obst_valid  <= state_n == LOCKED;
         obst_update <= upd_n;
         err_pulse   <= bad;
         err_count   <= err_n;
         link_lost   <= state_n == LOST;
      end
   end

endmodule
